intc_bus_sequencer: RTL and testbench

Bus sequencer and arbiter in front of the interrupt controller's two-address register port (addr 0 = command, addr 1 = data). It shares that port between the CPU and two hardware-driven sequences. The init sequence loads the enable and type byte registers from configuration inputs after reset or on request. The EOI sequence issues end-of-interrupt. Because both sequences clobber the controller's command register, the block shadows the CPU's last command write and restores it after each sequence, so software never sees its command change.

---
 rtl/intc_bus_sequencer.sv | 171 +++++++++++++++++
 tb/tb_intc_bus_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_bus_sequencer.sv
// Shares the interrupt controller's command/data port between the CPU and
// the init/EOI write sequences, restoring the CPU's last command afterwards.
module intc_bus_sequencer #(
  parameter int NUM_BYTES = 16,
  parameter bit AUTO_INIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   eoi_req,
  input  logic [8*NUM_BYTES-1:0] cfg_enable,
  input  logic [8*NUM_BYTES-1:0] cfg_type,
  input  logic                   cpu_cs,
  input  logic                   cpu_rwb,
  input  logic                   cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_ready,
  output logic                   intc_cs,
  output logic                   intc_rwb,
  output logic                   intc_addr,
  output logic [7:0]             intc_wdata,
  input  logic [7:0]             intc_rdata,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = 5;
  localparam logic [IW-1:0] NB = IW'(NUM_BYTES);
  localparam logic [IW-1:0] LAST = IW'(2*NUM_BYTES-1);

  typedef enum logic [1:0] {
    IDLE,
    SEQ_CMD,
    SEQ_DATA,
    RESTORE
  } state_t;

  state_t                 state;
  logic [7:0]             shadow_cmd;
  logic [3:0]             eoi_cnt;
  logic                   init_pend;
  logic [IW-1:0]          idx;
  logic                   is_init;
  logic [8*NUM_BYTES-1:0] en_snap;
  logic [8*NUM_BYTES-1:0] ty_snap;
  logic                   seq_addr;
  logic [7:0]             seq_wdata;

  logic idle;
  logic cpu_cmd_wr;
  logic go_init;
  logic go_eoi;
  logic eoi_inc;

  // Command byte: 0x1n selects enable byte n, 0x2n selects type byte n.
  function automatic logic [7:0] cmd_of(input logic [IW-1:0] i);
    if (i < NB)
      return 8'h10 | 8'(i);
    return 8'h20 | 8'(i - NB);
  endfunction

  function automatic logic [7:0] data_of(input logic [IW-1:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (i == IW'(k))
        b = en_snap[8*k +: 8];
      if (i == IW'(k + NUM_BYTES))
        b = ty_snap[8*k +: 8];
    end
    return b;
  endfunction

  always_comb begin
    idle       = (state == IDLE);
    cpu_cmd_wr = idle && cpu_cs && !cpu_rwb && !cpu_addr;
    go_init    = idle && init_pend;
    go_eoi     = idle && !init_pend && (eoi_cnt != 4'd0);
    eoi_inc    = eoi_req && ((eoi_cnt != 4'hF) || go_eoi);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shadow_cmd <= 8'h00;
      eoi_cnt    <= 4'd0;
      init_pend  <= AUTO_INIT;
      idx        <= '0;
      is_init    <= 1'b0;
      done       <= 1'b0;
      en_snap    <= '0;
      ty_snap    <= '0;
      seq_addr   <= 1'b0;
      seq_wdata  <= 8'h00;
    end else begin
      done      <= 1'b0;
      init_pend <= start | (init_pend & !go_init);
      eoi_cnt   <= eoi_cnt + {3'b0, eoi_inc} - {3'b0, go_eoi};
      if (cpu_cmd_wr)
        shadow_cmd <= cpu_wdata;
      unique case (state)
        IDLE: begin
          if (go_init) begin
            state     <= SEQ_CMD;
            is_init   <= 1'b1;
            idx       <= '0;
            en_snap   <= cfg_enable;
            ty_snap   <= cfg_type;
            seq_addr  <= 1'b0;
            seq_wdata <= 8'h10;
          end else if (go_eoi) begin
            state     <= SEQ_CMD;
            is_init   <= 1'b0;
            seq_addr  <= 1'b0;
            seq_wdata <= 8'hFF;
          end
        end
        SEQ_CMD: begin
          state     <= SEQ_DATA;
          seq_addr  <= 1'b1;
          seq_wdata <= is_init ? data_of(idx) : 8'h01;
        end
        SEQ_DATA: begin
          seq_addr <= 1'b0;
          if (is_init && (idx != LAST)) begin
            state     <= SEQ_CMD;
            idx       <= idx + 1'b1;
            seq_wdata <= cmd_of(idx + 1'b1);
          end else begin
            state     <= RESTORE;
            seq_wdata <= shadow_cmd;
          end
        end
        RESTORE: begin
          state <= IDLE;
          done  <= is_init;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces the port quiet even in the cycle reset is first seen.
  always_comb begin
    cpu_rdata = intc_rdata;
    if (reset) begin
      intc_cs    = 1'b0;
      intc_rwb   = 1'b1;
      intc_addr  = 1'b0;
      intc_wdata = 8'h00;
      cpu_ready  = 1'b0;
      busy       = 1'b0;
    end else if (idle) begin
      intc_cs    = cpu_cs;
      intc_rwb   = cpu_rwb;
      intc_addr  = cpu_addr;
      intc_wdata = cpu_wdata;
      cpu_ready  = 1'b1;
      busy       = 1'b0;
    end else begin
      intc_cs    = 1'b1;
      intc_rwb   = 1'b0;
      intc_addr  = seq_addr;
      intc_wdata = seq_wdata;
      cpu_ready  = 1'b0;
      busy       = 1'b1;
    end
  end

endmodule

// File: tb/tb_intc_bus_sequencer.sv
// Scoreboard bench for intc_bus_sequencer: request-level model pushes the
// expected port writes, a negedge monitor pops and compares them.
module tb_intc_bus_sequencer;

  localparam int NB = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            eoi_req;
  logic [8*NB-1:0] cfg_enable;
  logic [8*NB-1:0] cfg_type;
  logic            cpu_cs;
  logic            cpu_rwb;
  logic            cpu_addr;
  logic [7:0]      cpu_wdata;
  logic [7:0]      cpu_rdata;
  logic            cpu_ready;
  logic            intc_cs;
  logic            intc_rwb;
  logic            intc_addr;
  logic [7:0]      intc_wdata;
  logic [7:0]      intc_rdata;
  logic            busy;
  logic            done;

  intc_bus_sequencer #(
    .NUM_BYTES(NB),
    .AUTO_INIT(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .eoi_req   (eoi_req),
    .cfg_enable(cfg_enable),
    .cfg_type  (cfg_type),
    .cpu_cs    (cpu_cs),
    .cpu_rwb   (cpu_rwb),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .intc_cs   (intc_cs),
    .intc_rwb  (intc_rwb),
    .intc_addr (intc_addr),
    .intc_wdata(intc_wdata),
    .intc_rdata(intc_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int mis = 0;

  logic [8:0] exp_q[$];
  int         m_left = 0;
  bit         m_pend = 1'b1;
  int         m_cnt = 0;
  logic [7:0] m_shadow = 8'h00;
  bit         m_cur = 1'b0;
  bit         m_done = 1'b0;
  bit         acc = 1'b0;
  bit         rnd = 1'b0;

  // Sequence-level reference: each started sequence is a list of writes
  // plus a busy length; the port is free again when that length runs out.
  always @(posedge clk) begin
    if (reset) begin
      m_left   = 0;
      m_pend   = 1'b1;
      m_cnt    = 0;
      m_shadow = 8'h00;
      m_done   = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (cpu_cs && !cpu_rwb && !cpu_addr)
          m_shadow = cpu_wdata;
        if (m_pend) begin
          for (int i = 0; i < 2*NB; i++) begin
            if (i < NB) begin
              exp_q.push_back({1'b0, 8'(8'h10 + i)});
              exp_q.push_back({1'b1, cfg_enable[8*i +: 8]});
            end else begin
              exp_q.push_back({1'b0, 8'(8'h20 + i - NB)});
              exp_q.push_back({1'b1, cfg_type[8*(i-NB) +: 8]});
            end
          end
          exp_q.push_back({1'b0, m_shadow});
          m_left = 4*NB + 1;
          m_cur  = 1'b1;
          m_pend = 1'b0;
        end else if (m_cnt > 0) begin
          exp_q.push_back({1'b0, 8'hFF});
          exp_q.push_back({1'b1, 8'h01});
          exp_q.push_back({1'b0, m_shadow});
          m_left = 3;
          m_cur  = 1'b0;
          m_cnt  = m_cnt - 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0 && m_cur)
          m_done = 1'b1;
      end
      if (start)
        m_pend = 1'b1;
      if (eoi_req && m_cnt < 15)
        m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [8:0] w;
    if (reset) begin
      vec++;
      if (intc_cs !== 1'b0 || cpu_ready !== 1'b0 || busy !== 1'b0 ||
          intc_rwb !== 1'b1 || intc_addr !== 1'b0 || intc_wdata !== 8'h00) begin
        mis++;
        $display("FAIL reset_outputs t=%0t got cs=%b rdy=%b busy=%b rwb=%b a=%b d=%h want 0 0 0 1 0 00",
                 $time, intc_cs, cpu_ready, busy, intc_rwb, intc_addr, intc_wdata);
      end
    end else begin
      vec++;
      if (busy !== (m_left > 0) || cpu_ready !== (m_left == 0)) begin
        mis++;
        $display("FAIL busy_ready t=%0t got busy=%b rdy=%b want busy=%b",
                 $time, busy, cpu_ready, m_left > 0);
      end
      vec++;
      if (done !== m_done) begin
        mis++;
        $display("FAIL done t=%0t got %b want %b", $time, done, m_done);
      end
      if (m_left == 0 && busy === 1'b0) begin
        vec++;
        if (intc_cs !== cpu_cs || cpu_rdata !== intc_rdata ||
            (cpu_cs && (intc_rwb !== cpu_rwb || intc_addr !== cpu_addr ||
                        intc_wdata !== cpu_wdata))) begin
          mis++;
          $display("FAIL passthrough t=%0t got cs=%b rwb=%b a=%b d=%h rd=%h want cs=%b rwb=%b a=%b d=%h rd=%h",
                   $time, intc_cs, intc_rwb, intc_addr, intc_wdata, cpu_rdata,
                   cpu_cs, cpu_rwb, cpu_addr, cpu_wdata, intc_rdata);
        end
      end else if (busy === 1'b1 && intc_cs === 1'b1) begin
        vec++;
        if (exp_q.size() == 0) begin
          mis++;
          $display("FAIL unexpected_write t=%0t got a=%b d=%h want none",
                   $time, intc_addr, intc_wdata);
        end else begin
          w = exp_q.pop_front();
          if (intc_rwb !== 1'b0 || {intc_addr, intc_wdata} !== w) begin
            mis++;
            $display("FAIL seq_write t=%0t got rwb=%b a=%b d=%h want rwb=0 a=%b d=%h",
                     $time, intc_rwb, intc_addr, intc_wdata, w[8], w[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    acc = cpu_cs && cpu_ready;
    @(posedge clk);
    #1;
    start      = 1'b0;
    eoi_req    = 1'b0;
    intc_rdata = 8'($urandom);
    if (acc)
      cpu_cs = 1'b0;
    if (rnd && !cpu_cs && $urandom_range(0, 3) == 0) begin
      cpu_cs    = 1'b1;
      cpu_rwb   = 1'($urandom);
      cpu_addr  = 1'($urandom);
      cpu_wdata = 8'($urandom);
    end
  endtask

  task automatic cpu_op(input logic rwb, input logic addr, input logic [7:0] d);
    cpu_cs    = 1'b1;
    cpu_rwb   = rwb;
    cpu_addr  = addr;
    cpu_wdata = d;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (acc)
        return;
    end
    vec++;
    mis++;
    $display("FAIL cpu_timeout got no cpu_ready want accept within 300 cycles");
    cpu_cs = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    eoi_req    = 1'b0;
    cfg_enable = 16'hA55A;
    cfg_type   = 16'h0F01;
    cpu_cs     = 1'b0;
    cpu_rwb    = 1'b1;
    cpu_addr   = 1'b0;
    cpu_wdata  = 8'h00;
    intc_rdata = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (14) tick();

    cpu_op(1'b0, 1'b0, 8'h12);
    eoi_req = 1'b1;
    repeat (6) tick();

    start   = 1'b1;
    eoi_req = 1'b1;
    repeat (18) tick();

    start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      eoi_req = 1'b1;
      tick();
      tick();
    end
    repeat (25) tick();

    start = 1'b1;
    tick();
    tick();
    cpu_op(1'b1, 1'b1, 8'h00);
    repeat (3) tick();

    start = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (14) tick();

    start = 1'b1;
    tick();
    for (int k = 0; k < 18; k++) begin
      eoi_req = 1'b1;
      tick();
    end
    repeat (80) tick();

    rnd = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) start = 1'b1;
      if ($urandom_range(0, 14) == 0) eoi_req = 1'b1;
      if ($urandom_range(0, 49) == 0) cfg_enable = 16'($urandom);
      if ($urandom_range(0, 49) == 0) cfg_type = 16'($urandom);
      if ($urandom_range(0, 699) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    rnd = 1'b0;

    begin
      int n;
      n = 0;
      while ((cpu_cs || m_left != 0 || m_pend || m_cnt != 0) && n < 2000) begin
        tick();
        n++;
      end
      vec++;
      if (n >= 2000) begin
        mis++;
        $display("FAIL drain_timeout got still busy want idle within 2000 cycles");
      end
    end
    repeat (3) tick();
    vec++;
    if (exp_q.size() != 0) begin
      mis++;
      $display("FAIL leftover_writes got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
